store_checker: RTL
==================

Name: store_checker

Overview:
- Self-checking monitor sitting directly downstream of the processor top level; consumes its store bus (memwrite, dataadr, writedata).
- Decides pass/fail/timeout for the lab program run and logs every store into a small FIFO that the bench can drain.
- Synthesizable. Lets benches replace ad-hoc negedge checks with a single registered verdict.

Parameters:
- PASS_ADDR, 32'd84, store address that terminates the run.
- PASS_DATA, 32'd7, data required at PASS_ADDR for a pass.
- IGNORE_ADDR, 32'd80, address whose stores are tolerated (see Optional Feature).
- TIMEOUT, 200, clock cycles in RUN before declaring timeout; must be at least 2.
- LOG_DEPTH, 8, store-log FIFO entries; power of two.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- memwrite, input, 1, store strobe from the processor.
- dataadr, input, 32, store address.
- writedata, input, 32, store data.
- log_rd, input, 1, pop the log head; ignored when empty.
- log_valid, output, 1, log non-empty.
- log_addr, output, 32, address at the log head (show-ahead).
- log_data, output, 32, data at the log head (show-ahead).
- log_count, output, $clog2(LOG_DEPTH)+1, current occupancy.
- log_ovf, output, 1, sticky: a store was dropped because the log was full.
- done, output, 1, verdict reached.
- pass, output, 1, run passed.
- fail, output, 1, run failed due to a bad store or a timeout.
- timeout, output, 1, fail cause was a timeout.
- cycle_count, output, 32, cycles spent in RUN.

Behaviour:
- Reset, asynchronous:
  - State goes to RUN.
  - All outputs are 0: done, pass, fail, timeout, log_valid, log_count, log_ovf, cycle_count, log_addr, log_data.
  - FIFO pointers are cleared.
- States: RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal and hold until reset.
- Inputs are sampled at the rising edge. A store is a sampled edge with memwrite=1.
- Transitions out of RUN, evaluated in this priority order:
  1. Store with dataadr==PASS_ADDR and writedata==PASS_DATA goes to PASS.
  2. Store with dataadr==PASS_ADDR and any other writedata goes to FAIL.
  3. Store with any other non-tolerated address goes to FAIL.
  4. No terminating store and cycle_count==TIMEOUT-1 goes to TMO.
  - A store-based decision beats timeout in the same cycle.
- Verdict outputs are registered and assert on the edge that samples the deciding store (latency 1 cycle from the store being presented):
  - PASS: done=1, pass=1.
  - FAIL: done=1, fail=1.
  - TMO: done=1, fail=1, timeout=1.
  - pass and fail are never both 1.
- cycle_count increments on every edge in RUN, including the deciding edge, then freezes. It never wraps in practice because TIMEOUT bounds it.
- Log FIFO:
  - Every store sampled in RUN is pushed as {dataadr, writedata}, including the deciding store.
  - Stores are not pushed in terminal states.
  - Push when full drops the entry and sets log_ovf.
  - Simultaneous push and pop when full: both occur and count is unchanged.
  - Simultaneous push and pop when empty: push only.
  - Pop only when log_valid=1.
  - Pointers wrap modulo LOG_DEPTH.
  - log_addr and log_data are valid whenever log_valid=1 and update on the edge after a pop.
  - The log remains drainable in terminal states.
- Reset mid-run aborts the run; all log contents are discarded.

Optional Feature:
- Macro: STORE_CHK_IGNORE_EN.
- Defined: a store with dataadr==IGNORE_ADDR, any data, is tolerated. It is logged and RUN continues.
- Not defined: IGNORE_ADDR has no meaning, and any store to an address other than PASS_ADDR goes to FAIL.

Test Plan:
- Reset, then store (80,3), then (84,7) at cycle 5 with STORE_CHK_IGNORE_EN defined:
  - done=pass=1 after that edge; fail=0.
  - cycle_count=6.
  - Log drains to (80,3) then (84,7); log_count 2 to 0.
- Store (84,5): fail=1, timeout=0. A later (84,7) does not change the verdict and is not logged.
- Macro undefined, store (80,3): fail=1 on that edge.
- TIMEOUT=10, no stores: done=fail=timeout=1 after the 10th edge; cycle_count=10.
- TIMEOUT=10, store (84,7) on the 10th edge: pass=1, timeout=0 (store beats timeout).
- LOG_DEPTH=8, ten tolerated stores with no pops:
  - log_count=8, log_ovf=1.
  - Drain returns the first eight in order.
  - Push and pop on the same edge while full keeps count at 8.
- Assert reset mid-run after 3 logged stores: all outputs 0 immediately (asynchronous), and log_valid=0.

Source files
------------

// File: rtl/store_checker.sv
// Store-bus monitor: registered pass/fail/timeout verdict plus a show-ahead store-log FIFO.
// Define STORE_CHK_IGNORE_EN to tolerate (log and continue) stores to IGNORE_ADDR.
module store_checker #(
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  parameter int          TIMEOUT     = 200,
  parameter int          LOG_DEPTH   = 8,
  localparam int         AW          = $clog2(LOG_DEPTH),
  localparam int         CW          = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          log_rd,
  output logic          log_valid,
  output logic [31:0]   log_addr,
  output logic [31:0]   log_data,
  output logic [CW-1:0] log_count,
  output logic          log_ovf,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [31:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2,
    S_TMO  = 2'd3
  } state_e;

  localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LOG_DEPTH);
`ifdef STORE_CHK_IGNORE_EN
  localparam logic IGN_EN = 1'b1;
`else
  localparam logic IGN_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          done_q, pass_q, fail_q, tmo_q;
  logic [31:0]   cycle_count_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [31:0]   addr_mem [LOG_DEPTH];
  logic [31:0]   data_mem [LOG_DEPTH];

  logic in_run_s, tol_s, pass_hit_s, push_req_s, push_s, pop_s, drop_s, full_s, empty_s;

  assign in_run_s   = (state_q == S_RUN);
  assign pass_hit_s = (dataadr == PASS_ADDR);
  assign tol_s      = IGN_EN & (dataadr == IGNORE_ADDR);
  assign full_s     = (count_q == FULL_CNT);
  assign empty_s    = (count_q == {CW{1'b0}});
  assign pop_s      = log_rd & ~empty_s;
  assign push_req_s = memwrite & in_run_s;
  // A full log still accepts a push when a pop frees the head slot on the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;

  // Verdict decision: PASS_ADDR stores first, then bad stores, then timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (memwrite && pass_hit_s) begin
          state_d = (writedata == PASS_DATA) ? S_PASS : S_FAIL;
        end else if (memwrite && !tol_s) begin
          state_d = S_FAIL;
        end else if (cycle_count_q == TMO_LAST) begin
          state_d = S_TMO;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      tmo_q         <= 1'b0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d != S_RUN);
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL) || (state_d == S_TMO);
      tmo_q   <= (state_d == S_TMO);
      if (in_run_s) begin
        cycle_count_q <= cycle_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; the head is masked whenever the log is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem[wr_ptr_q] <= dataadr;
      data_mem[wr_ptr_q] <= writedata;
    end
  end

  assign log_valid   = ~empty_s;
  assign log_addr    = empty_s ? 32'd0 : addr_mem[rd_ptr_q];
  assign log_data    = empty_s ? 32'd0 : data_mem[rd_ptr_q];
  assign log_count   = count_q;
  assign log_ovf     = ovf_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign cycle_count = cycle_count_q;

endmodule
